// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deserializer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Two-of-three majority used for bit voting.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// Per-bit edge counter and 3-sample majority vote, shared by all bit states.
// sample_done is high while edge_cnt = PRESCALE/2+2, bit_end while edge_cnt = PRESCALE-1.
module rx_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic rx_s,
    input  logic run,
    input  logic clr,
    output logic bit_value,
    output logic sample_done,
    output logic bit_end
);

    localparam int unsigned CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] SMP0 = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] SMP1 = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] SMP2 = CW'(PRESCALE / 2 + 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 2);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] edge_cnt;
    logic          smp0;
    logic          smp1;

    // Edge counter, sample capture and vote; the counter idles at 0 when not running.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt    <= '0;
            smp0        <= 1'b1;
            smp1        <= 1'b1;
            bit_value   <= 1'b1;
            sample_done <= 1'b0;
            bit_end     <= 1'b0;
        end else if (!run || clr) begin
            edge_cnt    <= '0;
            sample_done <= 1'b0;
            bit_end     <= 1'b0;
        end else begin
            edge_cnt    <= (edge_cnt == LAST) ? '0 : edge_cnt + CW'(1);
            if (edge_cnt == SMP0) smp0 <= rx_s;
            if (edge_cnt == SMP1) smp1 <= rx_s;
            if (edge_cnt == SMP2) bit_value <= maj3(smp0, smp1, rx_s);
            sample_done <= (edge_cnt == SMP2);
            bit_end     <= (edge_cnt == PRE_LAST);
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizer, frame FSM, byte assembly and error strobes.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE   = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
`ifdef UART_RX_PARITY_EN
    input  logic                  PAR_TYP,
`endif
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BUSY
);

    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic                  rx_meta;
    logic                  rx_s;
    rx_state_e             state;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] hold;
    logic                  par_bad;
    logic                  bit_value;
    logic                  sample_done;
    logic                  bit_end;
    logic                  run_c;
    logic                  clr_c;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // The edge that first sees the start bit low is edge 0 of that bit.
    assign run_c = (state != IDLE) || !rx_s;
    // A start bit that votes high is a glitch; restart the counter with the FSM.
    assign clr_c = (state == START) && sample_done && bit_value;

    rx_bit_sampler #(
        .PRESCALE(PRESCALE)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .rx_s       (rx_s),
        .run        (run_c),
        .clr        (clr_c),
        .bit_value  (bit_value),
        .sample_done(sample_done),
        .bit_end    (bit_end)
    );

    // Frame FSM with byte assembly, checks and registered result strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            hold       <= '0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        BUSY    <= 1'b1;
                        par_bad <= 1'b0;
                    end
                end
                START: begin
                    if (clr_c) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (sample_done) hold[bit_cnt] <= bit_value;
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (sample_done) par_bad <= bit_value ^ (^hold) ^ (PAR_TYP == PAR_ODD);
`endif
                    if (bit_end) state <= STOP;
                end
                STOP: begin
                    if (bit_end) begin
                        STP_ERR <= !bit_value;
                        PAR_ERR <= par_bad;
                        if (bit_value && !par_bad) begin
                            DATA_VALID <= 1'b1;
                            P_DATA     <= hold;
                        end
                        if (!rx_s) begin
                            state   <= START;
                            par_bad <= 1'b0;
                        end else begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
